// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS control FSM with branch status register and memory watchdog
module multicycle_control #(
  parameter int OPW         = 6,
  parameter int FNW         = 6,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] opcode,
  input  logic [FNW-1:0] funct,
  input  logic           mem_ready,
  output logic           pc_write,
  output logic           pc_wcond,
  output logic           ir_write,
  output logic           iord,
  output logic           mem_read,
  output logic           mem_write,
  output logic           reg_write,
  output logic           regdest,
  output logic           memtoreg,
  output logic           alusrca,
  output logic [1:0]     alusrcb,
  output logic [1:0]     aluop,
  output logic [1:0]     pcsource,
  output logic [2:0]     status,
  output logic [3:0]     state,
  output logic           illegal
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  localparam logic [OPW-1:0] OP_R    = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_LW   = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW   = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_BMN  = OPW'(6'b010101);
  localparam logic [OPW-1:0] OP_BZ   = OPW'(6'b011000);
  localparam logic [OPW-1:0] OP_JALM = OPW'(6'b010011);
  localparam logic [FNW-1:0] FN_BRZ  = FNW'(6'b010100);
  localparam logic [FNW-1:0] FN_JMOR = FNW'(6'b100101);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_HALT   = 4'd10
  } state_t;

  typedef enum logic [2:0] {
    K_OTHER, K_R, K_LW, K_SW, K_BMN, K_JALM, K_JMOR, K_BR
  } kind_t;

  state_t        cur, nxt;
  kind_t         kind_q, dec_kind;
  logic [2:0]    status_q, dec_status;
  logic [CW-1:0] wd_cnt;
  logic          mem_wait, timeout;

  always_comb begin
    dec_kind   = K_OTHER;
    dec_status = 3'b000;
    case (opcode)
      OP_R: begin
        if (funct == FN_BRZ) begin
          dec_kind   = K_BR;
          dec_status = 3'b010;
        end else if (funct == FN_JMOR) begin
          dec_kind   = K_JMOR;
          dec_status = 3'b100;
        end else begin
          dec_kind   = K_R;
        end
      end
      OP_LW:   dec_kind = K_LW;
      OP_SW:   dec_kind = K_SW;
      OP_BEQ:  begin dec_kind = K_BR;   dec_status = 3'b111; end
      OP_BMN:  begin dec_kind = K_BMN;  dec_status = 3'b001; end
      OP_BZ:   begin dec_kind = K_BR;   dec_status = 3'b011; end
      OP_JALM: begin dec_kind = K_JALM; dec_status = 3'b101; end
      default: dec_kind = K_OTHER;
    endcase
  end

  // The limit is reached on the MEM_TIMEOUT-th consecutive stalled cycle, counting the current one.
  assign mem_wait = (cur == S_FETCH || cur == S_MEMRD || cur == S_MEMWR) && !mem_ready;
  assign timeout  = mem_wait && (wd_cnt == CW'(MEM_TIMEOUT - 1));

  always_comb begin
    nxt = cur;
    case (cur)
      S_FETCH:  if (mem_ready) nxt = S_DECODE; else if (timeout) nxt = S_HALT;
      S_DECODE: begin
        case (dec_kind)
          K_LW, K_SW, K_BMN, K_JALM: nxt = S_MEMADR;
          K_R:                       nxt = S_EXEC;
          K_BR:                      nxt = S_BRANCH;
          K_JMOR:                    nxt = S_JUMP;
          default:                   nxt = S_HALT;
        endcase
      end
      S_MEMADR: nxt = (kind_q == K_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (mem_ready)    nxt = (kind_q == K_LW) ? S_MEMWB : S_JUMP;
        else if (timeout) nxt = S_HALT;
      end
      S_MEMWB:  nxt = S_FETCH;
      S_MEMWR:  if (mem_ready) nxt = S_FETCH; else if (timeout) nxt = S_HALT;
      S_EXEC:   nxt = S_RWB;
      S_RWB:    nxt = S_FETCH;
      S_BRANCH: nxt = S_FETCH;
      S_JUMP:   nxt = S_FETCH;
      S_HALT:   nxt = S_HALT;
      default:  nxt = S_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur      <= S_FETCH;
      kind_q   <= K_OTHER;
      status_q <= 3'b000;
      wd_cnt   <= '0;
    end else begin
      cur <= nxt;
      if (nxt != cur)    wd_cnt <= '0;
      else if (mem_wait) wd_cnt <= wd_cnt + CW'(1);
      if (cur == S_DECODE) begin
        kind_q   <= dec_kind;
        status_q <= dec_status;
      end
    end
  end

  // Strobes are held low combinationally while reset is high, including the FETCH read request.
  always_comb begin
    pc_write  = 1'b0;
    pc_wcond  = 1'b0;
    ir_write  = 1'b0;
    iord      = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    regdest   = 1'b0;
    memtoreg  = 1'b0;
    alusrca   = 1'b0;
    alusrcb   = 2'b00;
    aluop     = 2'b00;
    pcsource  = 2'b00;
    if (!reset) begin
      case (cur)
        S_FETCH: begin
          mem_read = 1'b1;
          alusrcb  = 2'b01;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        S_DECODE: alusrcb = 2'b11;
        S_MEMADR: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        S_MEMWB: begin
          reg_write = 1'b1;
          memtoreg  = 1'b1;
        end
        S_MEMWR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        S_EXEC: begin
          alusrca = 1'b1;
          aluop   = 2'b10;
        end
        S_RWB: begin
          reg_write = 1'b1;
          regdest   = 1'b1;
        end
        S_BRANCH: begin
          alusrca  = 1'b1;
          aluop    = 2'b01;
          pcsource = 2'b01;
          pc_wcond = 1'b1;
        end
        S_JUMP: begin
          pc_write = 1'b1;
          pcsource = (kind_q == K_JMOR) ? 2'b10 : 2'b11;
        end
        default: ;
      endcase
    end
  end

  assign state   = cur;
  assign status  = status_q;
  assign illegal = !reset && (cur == S_HALT);

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control with directed instruction sequences
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_wcond, ir_write, iord, mem_read, mem_write;
  logic       reg_write, regdest, memtoreg, alusrca, illegal;
  logic [1:0] alusrcb, aluop, pcsource;
  logic [2:0] status;
  logic [3:0] state;

  multicycle_control #(.OPW(6), .FNW(6), .MEM_TIMEOUT(3)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_wcond(pc_wcond), .ir_write(ir_write), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write), .regdest(regdest),
    .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
    .pcsource(pcsource), .status(status), .state(state), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] vec;
    logic [3:0]  st;
    logic [2:0]  stat;
    logic        ill;
    string       nm;
  } exp_t;

  exp_t       sb[$];
  int         tests = 0;
  int         fails = 0;
  logic [5:0] cur_op = 6'd0;
  logic [5:0] cur_fn = 6'd0;

  // {pc_write,pc_wcond,ir_write,iord,mem_read,mem_write,reg_write,regdest,memtoreg,alusrca,alusrcb,aluop,pcsource}
  function automatic logic [15:0] exp_vec(input logic [3:0] st, input logic mr, input logic jmdr);
    case (st)
      4'd0:    return {mr, 1'b0, mr, 1'b0, 1'b1, 5'b00000, 2'b01, 2'b00, 2'b00};
      4'd1:    return {10'b0, 2'b11, 2'b00, 2'b00};
      4'd2:    return {9'b0, 1'b1, 2'b10, 2'b00, 2'b00};
      4'd3:    return 16'b0001_1000_0000_0000;
      4'd4:    return 16'b0000_0010_1000_0000;
      4'd5:    return 16'b0001_0100_0000_0000;
      4'd6:    return {9'b0, 1'b1, 2'b00, 2'b10, 2'b00};
      4'd7:    return 16'b0000_0011_0000_0000;
      4'd8:    return {1'b0, 1'b1, 7'b0, 1'b1, 2'b00, 2'b01, 2'b01};
      4'd9:    return {1'b1, 13'b0, jmdr ? 2'b11 : 2'b10};
      default: return 16'b0;
    endcase
  endfunction

  task automatic step(input logic [3:0] st, input logic mr, input logic [2:0] stat,
                      input logic jmdr, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    mem_ready = mr;
    opcode    = cur_op;
    funct     = cur_fn;
    e.vec  = exp_vec(st, mr, jmdr);
    e.st   = st;
    e.stat = stat;
    e.ill  = (st == 4'd10);
    e.nm   = nm;
    sb.push_back(e);
  endtask

  task automatic reset_cycle(input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    reset     = 1'b1;
    mem_ready = 1'b0;
    e.vec  = 16'b0;
    e.st   = 4'd0;
    e.stat = 3'b000;
    e.ill  = 1'b0;
    e.nm   = nm;
    sb.push_back(e);
  endtask

  task automatic set_instr(input logic [5:0] op, input logic [5:0] fn);
    cur_op = op;
    cur_fn = fn;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t        e;
      logic [15:0] got;
      e   = sb.pop_front();
      got = {pc_write, pc_wcond, ir_write, iord, mem_read, mem_write, reg_write, regdest,
             memtoreg, alusrca, alusrcb, aluop, pcsource};
      tests++;
      if (got !== e.vec || state !== e.st || status !== e.stat || illegal !== e.ill) begin
        fails++;
        $display("FAIL %s: got strobes=%b state=%0d status=%b illegal=%b, want strobes=%b state=%0d status=%b illegal=%b",
                 e.nm, got, state, status, illegal, e.vec, e.st, e.stat, e.ill);
      end
    end
  end

  initial begin
    reset_cycle("reset");

    // lw with mem_ready tied high: 5 cycles
    set_instr(6'b100011, 6'd0);
    step(0, 1, 3'b000, 0, "lw_fetch");
    step(1, 1, 3'b000, 0, "lw_decode");
    step(2, 1, 3'b000, 0, "lw_memadr");
    step(3, 1, 3'b000, 0, "lw_memrd");
    step(4, 1, 3'b000, 0, "lw_memwb");

    // add
    set_instr(6'b000000, 6'b100000);
    step(0, 1, 3'b000, 0, "add_fetch");
    step(1, 1, 3'b000, 0, "add_decode");
    step(6, 1, 3'b000, 0, "add_exec");
    step(7, 1, 3'b000, 0, "add_rwb");

    // beq, bmn, jmor
    set_instr(6'b000100, 6'd0);
    step(0, 1, 3'b000, 0, "beq_fetch");
    step(1, 1, 3'b000, 0, "beq_decode");
    step(8, 1, 3'b111, 0, "beq_branch");
    set_instr(6'b010101, 6'd0);
    step(0, 1, 3'b111, 0, "bmn_fetch");
    step(1, 1, 3'b111, 0, "bmn_decode");
    step(2, 1, 3'b001, 0, "bmn_memadr");
    step(3, 1, 3'b001, 0, "bmn_memrd");
    step(9, 1, 3'b001, 1, "bmn_jump");
    set_instr(6'b000000, 6'b100101);
    step(0, 1, 3'b001, 0, "jmor_fetch");
    step(1, 1, 3'b001, 0, "jmor_decode");
    step(9, 1, 3'b100, 0, "jmor_jump");

    // sw
    set_instr(6'b101011, 6'd0);
    step(0, 1, 3'b100, 0, "sw_fetch");
    step(1, 1, 3'b100, 0, "sw_decode");
    step(2, 1, 3'b000, 0, "sw_memadr");
    step(5, 1, 3'b000, 0, "sw_memwr");

    // brz and bz
    set_instr(6'b000000, 6'b010100);
    step(0, 1, 3'b000, 0, "brz_fetch");
    step(1, 1, 3'b000, 0, "brz_decode");
    step(8, 1, 3'b010, 0, "brz_branch");
    set_instr(6'b011000, 6'd0);
    step(0, 1, 3'b010, 0, "bz_fetch");
    step(1, 1, 3'b010, 0, "bz_decode");
    step(8, 1, 3'b011, 0, "bz_branch");

    // lw with 2 stalled MEMRD cycles then ready on the 3rd: completes
    set_instr(6'b100011, 6'd0);
    step(0, 1, 3'b011, 0, "lwslow_fetch");
    step(1, 1, 3'b011, 0, "lwslow_decode");
    step(2, 1, 3'b000, 0, "lwslow_memadr");
    step(3, 0, 3'b000, 0, "lwslow_memrd_w1");
    step(3, 0, 3'b000, 0, "lwslow_memrd_w2");
    step(3, 1, 3'b000, 0, "lwslow_memrd_ok");
    step(4, 1, 3'b000, 0, "lwslow_memwb");

    // fetch stall, then lw with 3 stalled MEMRD cycles: watchdog halts
    step(0, 0, 3'b000, 0, "lwto_fetch_stall");
    step(0, 1, 3'b000, 0, "lwto_fetch");
    step(1, 1, 3'b000, 0, "lwto_decode");
    step(2, 1, 3'b000, 0, "lwto_memadr");
    step(3, 0, 3'b000, 0, "lwto_memrd_w1");
    step(3, 0, 3'b000, 0, "lwto_memrd_w2");
    step(3, 0, 3'b000, 0, "lwto_memrd_w3");
    for (int i = 0; i < 4; i++) step(10, 1, 3'b000, 0, "lwto_halt");
    reset_cycle("reset_after_timeout");

    // beq to set status, then undefined opcode halts and stays halted
    set_instr(6'b000100, 6'd0);
    step(0, 1, 3'b000, 0, "beq2_fetch");
    step(1, 1, 3'b000, 0, "beq2_decode");
    step(8, 1, 3'b111, 0, "beq2_branch");
    set_instr(6'b111111, 6'd0);
    step(0, 1, 3'b111, 0, "ill_fetch");
    step(1, 1, 3'b111, 0, "ill_decode");
    for (int i = 0; i < 20; i++) step(10, (i % 2) == 0, 3'b000, 0, "ill_halt");
    reset_cycle("reset_after_illegal");

    // jalm interrupted by reset in MEMRD: status cleared
    set_instr(6'b010011, 6'd0);
    step(0, 1, 3'b000, 0, "jalm_fetch");
    step(1, 1, 3'b000, 0, "jalm_decode");
    step(2, 1, 3'b101, 0, "jalm_memadr");
    step(3, 0, 3'b101, 0, "jalm_memrd_wait");
    reset_cycle("reset_mid_jalm");

    // sw interrupted by reset in MEMWR, then lw runs normally
    set_instr(6'b101011, 6'd0);
    step(0, 1, 3'b000, 0, "sw2_fetch");
    step(1, 1, 3'b000, 0, "sw2_decode");
    step(2, 1, 3'b000, 0, "sw2_memadr");
    step(5, 0, 3'b000, 0, "sw2_memwr_w1");
    step(5, 0, 3'b000, 0, "sw2_memwr_w2");
    reset_cycle("reset_mid_memwr");
    set_instr(6'b100011, 6'd0);
    step(0, 1, 3'b000, 0, "lw3_fetch");
    step(1, 1, 3'b000, 0, "lw3_decode");
    step(2, 1, 3'b000, 0, "lw3_memadr");
    step(3, 1, 3'b000, 0, "lw3_memrd");
    step(4, 1, 3'b000, 0, "lw3_memwb");
    step(0, 0, 3'b000, 0, "lw3_next_fetch");

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
